// File: rtl/mmio_serial_hub.sv
// ============================================================================
// Module   : mmio_serial_hub
// Purpose  : Memory-mapped hub between the CPU data port and NCH byte-serial
//            channels: per-channel RX FIFO, TX holding register and sticky
//            overflow status. Optional IRQ/mask register via MMIO_HUB_IRQ_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mmio_serial_hub #(
    parameter int          NCH      = 2,
    parameter int          FIFO_DEP = 8,
    parameter logic [15:0] IO_BASE  = 16'hBF00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        mem_addr,
    input  logic [15:0]        mem_wdata,
    input  logic               mem_re,
    input  logic               mem_we,
    output logic [15:0]        mem_rdata,
    output logic               is_io,
    output logic [17:0]        ram_addr,
    input  logic [15:0]        ram_rdata,
    input  logic [8*NCH-1:0]   ch_rx_data,
    input  logic [NCH-1:0]     ch_rx_valid,
    output logic [8*NCH-1:0]   ch_tx_data,
    output logic [NCH-1:0]     ch_tx_valid,
`ifdef MMIO_HUB_IRQ_EN
    output logic               irq,
`endif
    input  logic [NCH-1:0]     ch_tx_ready
);

    localparam int AW = $clog2(FIFO_DEP);
    localparam int CW = AW + 1;
`ifdef MMIO_HUB_IRQ_EN
    localparam int NWIN = 2 * NCH + 1;
`else
    localparam int NWIN = 2 * NCH;
`endif
    localparam logic [15:0] WIN = 16'(NWIN);

    logic [15:0]    offset;
    logic [NCH-1:0] sel_data;
    logic [NCH-1:0] sel_stat;
    logic [NCH-1:0] rx_avail;
    logic [NCH-1:0] ovf;
    logic [NCH-1:0] tx_valid;
    logic [7:0]     head [NCH];
    logic           unused_bits;

    // Unsigned wrap of the subtraction makes addresses below IO_BASE fall out too
    assign offset      = mem_addr - IO_BASE;
    assign is_io       = offset < WIN;
    assign ram_addr    = {2'b00, mem_addr};
    assign ch_tx_valid = tx_valid;
    assign unused_bits = ^mem_wdata[15:8];

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            localparam logic [15:0] DOFS = 16'(2 * k);

            logic [7:0]    fifo_mem [FIFO_DEP];
            logic [AW-1:0] wr_ptr;
            logic [AW-1:0] rd_ptr;
            logic [CW-1:0] count;
            logic          full;
            logic          push;
            logic          pop;
            logic          ovf_flag;
            logic          tx_pend;
            logic [7:0]    tx_byte;

            assign sel_data[k] = is_io && (offset == DOFS);
            assign sel_stat[k] = is_io && (offset == DOFS + 16'd1);
            assign full        = (count == CW'(FIFO_DEP));
            assign pop         = mem_re && sel_data[k] && (count != '0);
            // A pop in the same cycle frees the slot, so a full FIFO still accepts
            assign push        = ch_rx_valid[k] && (!full || pop);

            always_ff @(posedge clk) begin
                if (!rst) begin
                    wr_ptr   <= '0;
                    rd_ptr   <= '0;
                    count    <= '0;
                    ovf_flag <= 1'b0;
                    tx_pend  <= 1'b0;
                    tx_byte  <= 8'h00;
                end else begin
                    if (push) wr_ptr <= wr_ptr + AW'(1);
                    if (pop)  rd_ptr <= rd_ptr + AW'(1);
                    if (push && !pop)
                        count <= count + CW'(1);
                    else if (pop && !push)
                        count <= count - CW'(1);
                    if (ch_rx_valid[k] && full && !pop)
                        ovf_flag <= 1'b1;
                    else if (mem_re && sel_stat[k])
                        ovf_flag <= 1'b0;
                    if (tx_pend && ch_tx_ready[k])
                        tx_pend <= 1'b0;
                    else if (mem_we && !mem_re && sel_data[k] && !tx_pend) begin
                        tx_pend <= 1'b1;
                        tx_byte <= mem_wdata[7:0];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (push) fifo_mem[wr_ptr] <= ch_rx_data[8*k +: 8];
            end

            assign head[k]                = (count != '0) ? fifo_mem[rd_ptr] : 8'h00;
            assign rx_avail[k]            = (count != '0);
            assign ovf[k]                 = ovf_flag;
            assign tx_valid[k]            = tx_pend;
            assign ch_tx_data[8*k +: 8]   = tx_byte;
        end
    endgenerate

`ifdef MMIO_HUB_IRQ_EN
    localparam logic [15:0] MOFS = 16'(2 * NCH);

    logic           sel_mask;
    logic [NCH-1:0] mask;

    assign sel_mask = is_io && (offset == MOFS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (mem_we && !mem_re && sel_mask) mask <= mem_wdata[NCH-1:0];
            irq <= |(rx_avail & mask);
        end
    end
`endif

    always_comb begin
        mem_rdata = 16'h0000;
        if (!is_io) begin
            mem_rdata = ram_rdata;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (sel_data[k]) mem_rdata = {8'h00, head[k]};
                if (sel_stat[k]) mem_rdata = {13'b0, ovf[k], rx_avail[k], ~tx_valid[k]};
            end
`ifdef MMIO_HUB_IRQ_EN
            if (sel_mask) mem_rdata = {{(16-NCH){1'b0}}, mask};
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_serial_hub.sv
// ============================================================================
// Module   : tb_mmio_serial_hub
// Purpose  : Scoreboard bench for mmio_serial_hub (NCH=2, FIFO_DEP=8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmio_serial_hub;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        is_io;
    logic [17:0] ram_addr;
    logic [15:0] ram_rdata;
    logic [15:0] ch_rx_data;
    logic [1:0]  ch_rx_valid;
    logic [15:0] ch_tx_data;
    logic [1:0]  ch_tx_valid;
    logic [1:0]  ch_tx_ready;
`ifdef MMIO_HUB_IRQ_EN
    logic        irq;
`endif

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] exp_q  [$];
    logic [15:0] addr_q [$];
    logic [15:0] mon_exp;
    logic [15:0] mon_addr;

    always #5 clk = ~clk;

    mmio_serial_hub #(.NCH(2), .FIFO_DEP(8), .IO_BASE(16'hBF00)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .is_io       (is_io),
        .ram_addr    (ram_addr),
        .ram_rdata   (ram_rdata),
        .ch_rx_data  (ch_rx_data),
        .ch_rx_valid (ch_rx_valid),
        .ch_tx_data  (ch_tx_data),
        .ch_tx_valid (ch_tx_valid),
`ifdef MMIO_HUB_IRQ_EN
        .irq         (irq),
`endif
        .ch_tx_ready (ch_tx_ready)
    );

    // Read monitor: every CPU read strobe is matched against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (mem_re) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rd_unexpected addr=%h got=%h want=<none>", mem_addr, mem_rdata);
                end else begin
                    mon_exp  = exp_q.pop_front();
                    mon_addr = addr_q.pop_front();
                    if (mem_rdata !== mon_exp) begin
                        n_bad++;
                        $display("FAIL rd@%h got=%h want=%h", mon_addr, mem_rdata, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e);
        mem_addr = a;
        mem_re   = 1'b1;
        exp_q.push_back(e);
        addr_q.push_back(a);
        step();
        mem_re = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        step();
        mem_we = 1'b0;
    endtask

    task automatic rx(input int ch, input logic [7:0] b);
        ch_rx_data[8*ch +: 8] = b;
        ch_rx_valid[ch]       = 1'b1;
        step();
        ch_rx_valid = '0;
    endtask

    initial begin
        rst = 1'b0; mem_addr = 16'h0; mem_wdata = 16'h0; mem_re = 1'b0; mem_we = 1'b0;
        ram_rdata = 16'h0; ch_rx_data = 16'h0; ch_rx_valid = '0; ch_tx_ready = '0;
        step(); step(); step();
        rst = 1'b1;

        chk("rst_tx_valid", 32'(ch_tx_valid), 32'h0);
        chk("rst_tx_data", 32'(ch_tx_data), 32'h0);
        rd(16'hBF01, 16'h0001);
        rd(16'hBF00, 16'h0000);

        // Two bytes on ch0, read back in order
        rx(0, 8'h41);
        rx(0, 8'h42);
        rd(16'hBF00, 16'h0041);
        rd(16'hBF00, 16'h0042);
        rd(16'hBF01, 16'h0001);

        // Nine bytes into ch1: ninth overflows
        for (int i = 1; i <= 9; i++) rx(1, 8'(i));
        rd(16'hBF03, 16'h0007);
        rd(16'hBF03, 16'h0003);
        for (int i = 1; i <= 8; i++) rd(16'hBF02, 16'(i));
        rd(16'hBF02, 16'h0000);
        rd(16'hBF03, 16'h0001);

        // Full ch0 with simultaneous push and pop
        for (int i = 0; i < 8; i++) rx(0, 8'(8'h10 + i));
        mem_addr = 16'hBF00; mem_re = 1'b1;
        exp_q.push_back(16'h0010); addr_q.push_back(16'hBF00);
        ch_rx_data[7:0] = 8'h20; ch_rx_valid[0] = 1'b1;
        step();
        mem_re = 1'b0; ch_rx_valid = '0;
        rd(16'hBF01, 16'h0003);
        for (int i = 1; i < 8; i++) rd(16'hBF00, 16'(8'h10 + i));
        rd(16'hBF00, 16'h0020);
        rd(16'hBF00, 16'h0000);
        rd(16'hBF01, 16'h0001);

        // TX holding register and handshake
        wr(16'hBF00, 16'h1255);
        chk("tx_valid_set", 32'(ch_tx_valid), 32'h1);
        chk("tx_data0", 32'(ch_tx_data[7:0]), 32'h55);
        wr(16'hBF00, 16'h0066);
        chk("tx_data_hold", 32'(ch_tx_data[7:0]), 32'h55);
        rd(16'hBF01, 16'h0000);
        ch_tx_ready = 2'b01;
        step();
        ch_tx_ready = 2'b00;
        chk("tx_valid_drop", 32'(ch_tx_valid), 32'h0);
        rd(16'hBF01, 16'h0001);

        // Overflow set wins over a clearing status read
        for (int i = 0; i < 9; i++) rx(1, 8'(8'h30 + i));
        mem_addr = 16'hBF03; mem_re = 1'b1;
        exp_q.push_back(16'h0007); addr_q.push_back(16'hBF03);
        ch_rx_data[15:8] = 8'h39; ch_rx_valid[1] = 1'b1;
        step();
        mem_re = 1'b0; ch_rx_valid = '0;
        rd(16'hBF03, 16'h0007);
        rd(16'hBF03, 16'h0003);
        rd(16'hBF02, 16'h0030);

        // Reset mid-transfer discards TX byte and FIFO contents
        wr(16'hBF02, 16'h00AB);
        chk("tx1_valid", 32'(ch_tx_valid), 32'h2);
        chk("tx1_data", 32'(ch_tx_data[15:8]), 32'hAB);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_tx_valid", 32'(ch_tx_valid), 32'h0);
        chk("midrst_tx_data", 32'(ch_tx_data), 32'h0);
        rd(16'hBF03, 16'h0001);
        rd(16'hBF02, 16'h0000);

        // Ignored writes: status reg, outside window, read+write together
        wr(16'hBF01, 16'h00FF);
        chk("stat_wr_noeffect", 32'(ch_tx_valid), 32'h0);
        wr(16'h1234, 16'h0099);
        chk("ram_wr_noeffect", 32'(ch_tx_valid), 32'h0);
        mem_addr = 16'hBF00; mem_wdata = 16'h0077; mem_re = 1'b1; mem_we = 1'b1;
        exp_q.push_back(16'h0000); addr_q.push_back(16'hBF00);
        step();
        mem_re = 1'b0; mem_we = 1'b0;
        chk("rdwr_noeffect", 32'(ch_tx_valid), 32'h0);

        // SRAM pass-through and window edges
        ram_rdata = 16'hBEEF;
        mem_addr  = 16'h1234;
        #1;
        chk("ram_is_io", 32'(is_io), 32'h0);
        chk("ram_addr", 32'(ram_addr), 32'h01234);
        rd(16'h1234, 16'hBEEF);
        rd(16'hBEFF, 16'hBEEF);
        mem_addr = 16'hBF03;
        #1;
        chk("top_ch_is_io", 32'(is_io), 32'h1);
        mem_addr = 16'hBF05;
        #1;
        chk("past_win_is_io", 32'(is_io), 32'h0);
        mem_addr = 16'hBF04;
        #1;
`ifdef MMIO_HUB_IRQ_EN
        chk("mask_is_io", 32'(is_io), 32'h1);
        rd(16'hBF04, 16'h0000);
        wr(16'hBF04, 16'h0002);
        rd(16'hBF04, 16'h0002);
        chk("irq_idle", 32'(irq), 32'h0);
        rx(1, 8'h77);
        chk("irq_one_edge", 32'(irq), 32'h0);
        step();
        chk("irq_two_edges", 32'(irq), 32'h1);
        rd(16'hBF02, 16'h0077);
        step();
        chk("irq_clear", 32'(irq), 32'h0);
`else
        chk("bf04_is_io", 32'(is_io), 32'h0);
        rd(16'hBF04, 16'hBEEF);
`endif

        step(); step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
